// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder: combinational sum/carry from four chained full adders,
// plus a registered copy of the result with carry, overflow, zero and negative flags.

module rca_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module ripple_carry_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       b0,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       cin,
    output logic       sum0,
    output logic       sum1,
    output logic       sum2,
    output logic       sum3,
    output logic       cout,
    output logic [3:0] sum_q,
    output logic       cout_q,
    output logic       ovf_q,
    output logic       zero_q,
    output logic       neg_q
);

    localparam int unsigned W = 4;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_sum;
    logic [W:0]   w_c;
    logic         w_ovf;
    logic         w_zero;

    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;
    logic         r_neg;

    assign w_a    = {a3, a2, a1, a0};
    assign w_b    = {b3, b2, b1, b0};
    assign w_c[0] = cin;

    // Carry ripples strictly stage to stage; no lookahead.
    for (genvar i = 0; i < W; i++) begin : g_stage
        rca_full_adder u_fa (
            .i_a (w_a[i]),
            .i_b (w_b[i]),
            .i_c (w_c[i]),
            .o_s (w_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    assign sum0 = w_sum[0];
    assign sum1 = w_sum[1];
    assign sum2 = w_sum[2];
    assign sum3 = w_sum[3];
    assign cout = w_c[W];

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign w_ovf  = w_c[W-1] ^ w_c[W];
    assign w_zero = (w_sum == W'(0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_c[W];
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
            r_neg  <= w_sum[W-1];
        end
    end

    assign sum_q  = r_sum;
    assign cout_q = r_cout;
    assign ovf_q  = r_ovf;
    assign zero_q = r_zero;
    assign neg_q  = r_neg;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: arithmetic model, scoreboard queue
// for the registered path, and asynchronous reset checks.

module tb_ripple_carry_adder;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a0, a1, a2, a3;
    logic       b0, b1, b2, b3;
    logic       cin;
    logic       sum0, sum1, sum2, sum3;
    logic       cout;
    logic [3:0] sum_q;
    logic       cout_q, ovf_q, zero_q, neg_q;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #20 clk = ~clk;

    ripple_carry_adder dut (
        .clk    (clk),
        .rst    (rst),
        .a0     (a0),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .b0     (b0),
        .b1     (b1),
        .b2     (b2),
        .b3     (b3),
        .cin    (cin),
        .sum0   (sum0),
        .sum1   (sum1),
        .sum2   (sum2),
        .sum3   (sum3),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q),
        .zero_q (zero_q),
        .neg_q  (neg_q)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer addition, overflow from signed range
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t e;
        int   u;
        int   s;
        u = int'(a) + int'(b) + int'(c);
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.sum  = 4'(u);
        e.cout = (u > 15);
        e.ovf  = (s > 7) || (s < -8);
        e.zero = (e.sum == 4'd0);
        e.neg  = e.sum[3];
        return e;
    endfunction

    task automatic check_regs_zero(input string tag);
        check_eq({tag, "_sum_q"},  8'(sum_q),  8'd0);
        check_eq({tag, "_cout_q"}, 8'(cout_q), 8'd0);
        check_eq({tag, "_ovf_q"},  8'(ovf_q),  8'd0);
        check_eq({tag, "_zero_q"}, 8'(zero_q), 8'd0);
        check_eq({tag, "_neg_q"},  8'(neg_q),  8'd0);
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t e;
        exp_t got;
        @(negedge clk);
        {a3, a2, a1, a0} = a;
        {b3, b2, b1, b0} = b;
        cin = c;
        e = model(a, b, c);
        sb.push_back(e);
        #10;
        check_eq("comb_sum",  8'({sum3, sum2, sum1, sum0}), 8'(e.sum));
        check_eq("comb_cout", 8'(cout), 8'(e.cout));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 8'd0, 8'd1);
        end else begin
            got = sb.pop_front();
            check_eq("sum_q",  8'(sum_q),  8'(got.sum));
            check_eq("cout_q", 8'(cout_q), 8'(got.cout));
            check_eq("ovf_q",  8'(ovf_q),  8'(got.ovf));
            check_eq("zero_q", 8'(zero_q), 8'(got.zero));
            check_eq("neg_q",  8'(neg_q),  8'(got.neg));
        end
    endtask

    initial begin
        rst = 1'b1;
        {a3, a2, a1, a0} = 4'd0;
        {b3, b2, b1, b0} = 4'd0;
        cin = 1'b0;
        #1;
        check_regs_zero("reset");
        @(posedge clk);
        #1;
        check_regs_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        apply(4'd2,  4'd5,  1'b0);
        apply(4'd7,  4'd10, 1'b0);
        apply(4'd12, 4'd5,  1'b0);
        apply(4'd8,  4'd9,  1'b0);
        apply(4'd15, 4'd0,  1'b1);
        apply(4'd7,  4'd1,  1'b0);
        check_eq("ovf_7p1", 8'(ovf_q), 8'd1);
        check_eq("neg_7p1", 8'(neg_q), 8'd1);
        apply(4'd15, 4'd1,  1'b0);
        apply(4'd15, 4'd15, 1'b1);
        apply(4'd0,  4'd0,  1'b0);

        for (int i = 0; i < 24; i++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        apply(4'd8, 4'd8, 1'b0);
        check_eq("zero_8p8", 8'(zero_q), 8'd1);
        check_eq("cout_8p8", 8'(cout_q), 8'd1);
        check_eq("ovf_8p8",  8'(ovf_q),  8'd1);

        // Asynchronous reset between edges clears registers only
        #5;
        rst = 1'b1;
        sb.delete();
        #1;
        check_regs_zero("mid_rst");
        check_eq("mid_rst_comb_sum",  8'({sum3, sum2, sum1, sum0}), 8'd0);
        check_eq("mid_rst_comb_cout", 8'(cout), 8'd1);
        @(posedge clk);
        #1;
        check_regs_zero("mid_rst_hold");
        @(negedge clk);
        rst = 1'b0;

        apply(4'd2, 4'd5, 1'b0);
        check_eq("post_rst_sum_q",  8'(sum_q),  8'd7);
        check_eq("post_rst_cout_q", 8'(cout_q), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
